// File: rtl/ntt_pipe_sched.sv
// Issue scheduler for a fixed-latency NTT butterfly datapath; tracks in-flight ops in a tag pipeline.
// Optional stall statistics output is enabled by defining NTT_SCHED_STALL_STAT_EN.
module ntt_pipe_sched #(
    parameter int LATENCY = 8,
    parameter int ADDR    = 8,
    parameter int CNTW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR-1:0] op_count,
    input  logic [ADDR-1:0] base_addr,
    input  logic            hold,
    output logic            rd_en,
    output logic [ADDR-1:0] rd_addr,
    output logic            wr_en,
    output logic [ADDR-1:0] wr_addr,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] inflight
`ifdef NTT_SCHED_STALL_STAT_EN
    ,
    output logic [ADDR+7:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [ADDR-1:0]   ptr;
    logic [ADDR-1:0]   rem;
    logic [ADDR-1:0]   iss_addr;
    logic [ADDR-1:0]   rem_left;
    logic              issue;
    logic              pipe_fill;
    logic [LATENCY-1:0] tag_vld_p;
    logic [ADDR-1:0]   tag_addr_p [LATENCY];

`ifdef NTT_SCHED_STALL_STAT_EN
    localparam int SW = ADDR + 8;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (&v) ? v : v + SW'(1);
    endfunction
`endif

    assign wr_en   = tag_vld_p[LATENCY-1];
    assign wr_addr = tag_addr_p[LATENCY-1];

    // The first issue happens on the same edge that accepts start, so rd_en follows start by one cycle.
    always_comb begin
        issue    = 1'b0;
        iss_addr = ptr;
        rem_left = rem - ADDR'(1);
        if (state == S_IDLE && start && op_count != '0) begin
            issue    = !hold;
            iss_addr = base_addr;
            rem_left = op_count - ADDR'(1);
        end else if (state == S_ISSUE) begin
            issue = !hold;
        end
        // Occupancy the pipeline will hold after this edge, ignoring the entry now leaving it.
        pipe_fill = rd_en;
        for (int i = 0; i < LATENCY - 1; i++) begin
            pipe_fill = pipe_fill | tag_vld_p[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            inflight  <= '0;
            tag_vld_p <= '0;
`ifdef NTT_SCHED_STALL_STAT_EN
            stall_cycles <= '0;
`endif
        end else begin
            rd_en <= issue;
            if (issue) rd_addr <= iss_addr;

            // Tag pipeline stage boundaries: stage 0 mirrors the issue register
            tag_vld_p[0] <= rd_en;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
            end

            unique case ({rd_en, wr_en})
                2'b10:   inflight <= inflight + CNTW'(1);
                2'b01:   inflight <= inflight - CNTW'(1);
                default: inflight <= inflight;
            endcase

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
`ifdef NTT_SCHED_STALL_STAT_EN
                        stall_cycles <= '0;
`endif
                        if (op_count == '0)                state <= S_DONE;
                        else if (issue && op_count == ADDR'(1)) state <= S_DRAIN;
                        else                               state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef NTT_SCHED_STALL_STAT_EN
                    if (hold) stall_cycles <= sat_inc(stall_cycles);
`endif
                    if (issue && rem == ADDR'(1)) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!pipe_fill) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // An empty job arrives here with done low and spends one extra cycle before the pulse.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Address payloads carry no reset except the stage that drives wr_addr.
    always_ff @(posedge clk) begin
        if (issue) begin
            ptr <= iss_addr + ADDR'(1);
            rem <= rem_left;
        end else if (state == S_IDLE && start) begin
            ptr <= base_addr;
            rem <= op_count;
        end
        tag_addr_p[0] <= rd_addr;
        for (int i = 1; i < LATENCY; i++) begin
            tag_addr_p[i] <= tag_addr_p[i-1];
        end
        if (!reset) tag_addr_p[LATENCY-1] <= '0;
    end

endmodule

// File: tb/tb_ntt_pipe_sched.sv
// Self-checking bench for ntt_pipe_sched: job table plus scoreboard of expected read/write addresses.
module tb_ntt_pipe_sched;
    localparam int LATENCY = 8;
    localparam int ADDR    = 8;
    localparam int CNTW    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [ADDR-1:0] op_count;
    logic [ADDR-1:0] base_addr;
    logic            hold;
    logic            rd_en;
    logic [ADDR-1:0] rd_addr;
    logic            wr_en;
    logic [ADDR-1:0] wr_addr;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] inflight;
`ifdef NTT_SCHED_STALL_STAT_EN
    logic [ADDR+7:0] stall_cycles;
`endif

    ntt_pipe_sched #(.LATENCY(LATENCY), .ADDR(ADDR), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .start(start), .op_count(op_count),
        .base_addr(base_addr), .hold(hold), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done),
        .inflight(inflight)
`ifdef NTT_SCHED_STALL_STAT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [ADDR-1:0] addr;
        int              due;
    } wr_t;

    typedef struct {
        int              n;
        logic [ADDR-1:0] base;
        int              hold_off;
        int              hold_len;
        int              busy_off;
        int              exp_done;
        int              exp_peak;
        int              exp_stall;
    } job_t;

    logic [ADDR-1:0] exp_rd[$];
    wr_t             exp_wr[$];
    int              inf_m = 0;
    int              max_inf = 0;
    int              exp_done_cyc = -1;
    int              done_seen_cyc = -1;
    bit              mon_en = 0;
    logic [ADDR-1:0] m_addr;
    wr_t             m_wr;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endfunction

    // Scoreboard: reads popped against expected addresses, writes due LATENCY cycles after each read
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_extra", 32'(rd_addr) + 32'h100, 32'(rd_addr));
                end else begin
                    m_addr = exp_rd.pop_front();
                    chk("rd_addr", 32'(rd_addr), 32'(m_addr));
                    exp_wr.push_back('{m_addr, cyc + LATENCY});
                end
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_extra", 32'(wr_addr) + 32'h100, 32'(wr_addr));
                end else begin
                    m_wr = exp_wr.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(m_wr.addr));
                    chk("wr_cycle", 32'(cyc), 32'(m_wr.due));
                end
            end
            if (exp_wr.size() > 0 && exp_wr[0].due < cyc) begin
                chk("wr_missing", 32'(exp_wr[0].due), 32'(cyc));
                void'(exp_wr.pop_front());
            end
            chk("inflight", 32'(inflight), 32'(inf_m));
            chk("inflight_bound", 32'(inflight > CNTW'(LATENCY)), 32'(0));
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
            if (rd_en && !wr_en)      inf_m++;
            else if (!rd_en && wr_en) inf_m--;
            if (done || cyc == exp_done_cyc) begin
                chk("done_cycle", 32'(done), 32'(cyc == exp_done_cyc));
                chk("busy_with_done", 32'(busy), 32'(1));
            end
            if (done) done_seen_cyc = cyc;
        end
    end

    task automatic run_job(input job_t j);
        int s;
        bit got;
        @(posedge clk); #1;
        s = cyc;
        start = 1'b1;
        op_count = 8'(j.n);
        base_addr = j.base;
        max_inf = 0;
        done_seen_cyc = -1;
        exp_done_cyc = s + j.exp_done;
        for (int i = 0; i < j.n; i++) exp_rd.push_back(j.base + 8'(i));
        got = 0;
        for (int k = 0; k < 120 && !got; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (j.busy_off > 0 && cyc == s + j.busy_off) begin
                start = 1'b1;
                op_count = 8'd7;
                base_addr = 8'h20;
            end
            hold = (j.hold_len > 0 && cyc >= s + j.hold_off && cyc < s + j.hold_off + j.hold_len);
            got = (done_seen_cyc >= 0);
        end
        start = 1'b0;
        hold = 1'b0;
        chk("done_seen", 32'(got), 32'(1));
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'(0));
        chk("done_width", 32'(done), 32'(0));
        chk("rd_left", 32'(exp_rd.size()), 32'(0));
        chk("wr_left", 32'(exp_wr.size()), 32'(0));
        chk("peak_inflight", 32'(max_inf), 32'(j.exp_peak));
`ifdef NTT_SCHED_STALL_STAT_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(j.exp_stall));
        @(negedge clk);
        chk("stall_hold", 32'(stall_cycles), 32'(j.exp_stall));
`endif
        exp_done_cyc = -1;
        exp_rd.delete();
        exp_wr.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"},    32'(rd_en),    32'(0));
        chk({tag, "_rd_addr"},  32'(rd_addr),  32'(0));
        chk({tag, "_wr_en"},    32'(wr_en),    32'(0));
        chk({tag, "_wr_addr"},  32'(wr_addr),  32'(0));
        chk({tag, "_busy"},     32'(busy),     32'(0));
        chk({tag, "_done"},     32'(done),     32'(0));
        chk({tag, "_inflight"}, 32'(inflight), 32'(0));
`ifdef NTT_SCHED_STALL_STAT_EN
        chk({tag, "_stall"},    32'(stall_cycles), 32'(0));
`endif
    endtask

    job_t jobs[7];

    initial begin
        bit found;
        // n, base, hold_off, hold_len, busy_off, done offset, peak inflight, stall count
        jobs[0] = '{4,  8'h10, 0, 0, 0, 13, 4, 0};
        jobs[1] = '{6,  8'h40, 2, 3, 0, 18, 5, 3};
        jobs[2] = '{0,  8'h33, 0, 0, 0, 2,  0, 0};
        jobs[3] = '{12, 8'hFE, 0, 0, 0, 21, 8, 0};
        jobs[4] = '{1,  8'h00, 0, 0, 0, 10, 1, 0};
        jobs[5] = '{5,  8'h80, 0, 0, 3, 14, 5, 0};
        jobs[6] = '{3,  8'hC0, 4, 5, 0, 12, 3, 0};

        reset = 1'b0;
        start = 1'b0;
        hold = 1'b0;
        op_count = '0;
        base_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        inf_m = 0;
        mon_en = 1;

        for (int t = 0; t < 7; t++) run_job(jobs[t]);

        // Reset while five operations are in flight: nothing may come out afterwards
        @(posedge clk); #1;
        start = 1'b1;
        op_count = 8'd10;
        base_addr = 8'h50;
        exp_done_cyc = -1;
        for (int i = 0; i < 10; i++) exp_rd.push_back(8'h50 + 8'(i));
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            found = (inflight == CNTW'(5));
        end
        chk("reset_trigger", 32'(found), 32'(1));
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_rd.delete();
        exp_wr.delete();
        inf_m = 0;
        @(negedge clk);
        check_zero("midjob_reset");
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_idle_busy", 32'(busy), 32'(0));

        run_job(jobs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_pipe_sched.md
Name: ntt_pipe_sched

Overview:
- Issue scheduler for a fixed-latency NTT butterfly datapath whose latency comes from parameterised delay lines.
- On a start command it issues a programmed number of operations, one per cycle, as read enable/address.
- It tracks every in-flight operation through an internal tag pipeline of depth LATENCY and emits the matching write enable/address exactly LATENCY cycles after issue.
- An external hold pauses issue only. Operations already in flight always complete.

Parameters:
- LATENCY, 8, datapath depth in cycles from rd_en to result valid; legal range >= 1.
- ADDR, 8, address width; also the width of op_count.
- CNTW, 4, width of the inflight counter; must satisfy 2^CNTW > LATENCY.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- op_count  in  ADDR  number of operations in the job; sampled with start.
- base_addr  in  ADDR  first read address; sampled with start.
- hold  in  1  when high, no issue occurs this cycle.
- rd_en  out  1  operation issued this cycle.
- rd_addr  out  ADDR  address of the issued operation.
- wr_en  out  1  result valid this cycle.
- wr_addr  out  ADDR  write-back address; equals the rd_addr issued LATENCY cycles earlier.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a job completes.
- inflight  out  CNTW  number of issued operations whose results are not yet written.

Behaviour:
- All outputs are registered. While reset is low at a clock edge, all outputs go to 0, the FSM goes to IDLE and every tag-pipeline valid bit is cleared. Address payloads need not be cleared.
- FSM has four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches op_count into a remaining counter and base_addr into an address pointer.
  - If op_count≠0, go to ISSUE. If op_count=0, go to DONE (no rd_en, no wr_en).
- ISSUE:
  - Each cycle with hold=0: rd_en=1, rd_addr=pointer, pointer+1 (wraps modulo 2^ADDR), remaining−1.
  - Each cycle with hold=1: rd_en=0, and pointer and remaining are unchanged.
  - When the final issue happens (remaining becomes 0), go to DRAIN.
  - A start that arrives while busy is ignored. Its op_count and base_addr are not sampled.
- Timing: start high at edge k gives the first rd_en during cycle k+1, provided hold is low at edge k.
- Tag pipeline:
  - LATENCY stages, each holding {valid, addr}.
  - Stage 0 loads {issue, rd_addr} every cycle; each later stage loads from the previous one.
  - wr_en and wr_addr are driven from the last stage.
  - wr_en is never gated by hold.
- inflight:
  - Counts +1 on a cycle with rd_en only, −1 on a cycle with wr_en only.
  - Unchanged when both or neither occur.
  - Never exceeds LATENCY.
- DRAIN: wait until the tag pipeline holds no valid entry after the last wr_en, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy goes low in the same cycle done deasserts.
- Simultaneous events:
  - The last issue and an earlier wr_en in the same cycle are both honoured.
  - hold during DRAIN has no effect.
- Reset in the middle of a job:
  - No wr_en is produced after reset, even for operations issued before it.
  - done does not pulse for the aborted job.
- Address wrap: base_addr=2^ADDR−2 with op_count=4 issues addresses 254, 255, 0, 1 (for ADDR=8).

Optional Feature:
- Macro: NTT_SCHED_STALL_STAT_EN.
- When defined:
  - Adds output stall_cycles, ADDR+8 bits wide.
  - Counts cycles spent in ISSUE with hold=1.
  - Clears on the start that launches a job and saturates at its maximum value.
  - Holds its value after done until the next start.
  - Resets to 0.
- When not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic job: LATENCY=8, start with op_count=4, base_addr=0x10, hold=0 → rd_en in cycles 1–4 with addresses 0x10–0x13; wr_en in cycles 9–12 with the same addresses; done in cycle 13; inflight peaks at 4.
- Hold mid-issue: op_count=6, hold high for 3 cycles after the 2nd issue → exactly 6 rd_en with consecutive addresses; a 3-cycle gap in rd_en and the same gap in wr_en; with the macro defined, stall_cycles=3.
- Empty and busy start: op_count=0 → done pulses 2 cycles after start, no rd_en or wr_en. A second start while busy → no effect on the current job, and its address is never issued.
- Wrap and full pipe: ADDR=8, base=0xFE, op_count=12, LATENCY=8 → addresses wrap 0xFF→0x00; inflight saturates at 8 while simultaneous rd_en and wr_en occur; done after the 12th wr_en.
- Reset mid-job: reset asserted low for one cycle while inflight=5 → all outputs 0 on the next cycle, no wr_en afterwards, no done; a new start then runs cleanly.
